// File: rtl/pio_pkg.sv
// ============================================================================
// Module : pio_pkg
// Brief  : Register map and edge-type encodings shared by the input PIO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA     = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE_CAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage : pio_pkg

`default_nettype wire

// File: rtl/pio_in_debounce.sv
// ============================================================================
// Module : pio_in_debounce
// Brief  : One input bit: 2-FF synchroniser followed by an optional debouncer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pio_in_debounce #(
    parameter int   DEBOUNCE_CYCLES = 0,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic stable_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= RESET_LEVEL;
            s2_q <= RESET_LEVEL;
        end else begin
            s1_q <= pin_i;
            s2_q <= s1_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable_o = s2_q;
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             stable_q;
            logic             stable_d;

            // Counter only runs while the synchronised bit disagrees; any agreement restarts it.
            always_comb begin
                cnt_d    = '0;
                stable_d = stable_q;
                if (s2_q != stable_q) begin
                    if (cnt_q == c_last_cnt) begin
                        stable_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q    <= '0;
                    stable_q <= RESET_LEVEL;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign stable_o = stable_q;
        end
    endgenerate

endmodule : pio_in_debounce

`default_nettype wire

// File: rtl/de2_115_qsys_key_pio_in.sv
// ============================================================================
// Module : de2_115_qsys_key_pio_in
// Brief  : Avalon-MM input PIO with per-bit sync/debounce, edge capture and IRQ.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module de2_115_qsys_key_pio_in
    import pio_pkg::*;
#(
    parameter int   WIDTH           = 4,
    parameter int   EDGE_TYPE       = 1,
    parameter int   DEBOUNCE_CYCLES = 0,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rd_mux;
    logic             w_wr;

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_cap_q;
    logic [WIDTH-1:0] edge_cap_d;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] irq_mask_d;
    logic [31:0]      readdata_q;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            pio_in_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_LEVEL     (RESET_LEVEL)
            ) u_debounce (
                .clk      (clk),
                .reset_n  (reset_n),
                .pin_i    (in_port[i]),
                .stable_o (w_stable[i])
            );
        end

        if (WIDTH < 32) begin : g_unused_wdata
            logic w_unused_wdata;
            assign w_unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  w_edge = w_stable & ~prev_q;
            EDGE_FALLING: w_edge = ~w_stable & prev_q;
            default:      w_edge = w_stable ^ prev_q;
        endcase
    end

    assign w_wr = chipselect && !write_n;

    // A fresh edge takes priority over a same-cycle write-1-to-clear of that bit.
    always_comb begin
        w_clr      = '0;
        irq_mask_d = irq_mask_q;
        if (w_wr && (address == PIO_ADDR_EDGE_CAP)) begin
            w_clr = writedata[WIDTH-1:0];
        end
        if (w_wr && (address == PIO_ADDR_IRQ_MASK)) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        edge_cap_d = w_edge | (edge_cap_q & ~w_clr);
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            PIO_ADDR_DATA:     w_rd_mux = w_stable;
            PIO_ADDR_IRQ_MASK: w_rd_mux = irq_mask_q;
            PIO_ADDR_EDGE_CAP: w_rd_mux = edge_cap_q;
            default:           w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= {WIDTH{RESET_LEVEL}};
            edge_cap_q <= '0;
            irq_mask_q <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= w_stable;
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
            readdata_q <= 32'(w_rd_mux);
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule : de2_115_qsys_key_pio_in

`default_nettype wire

// File: tb/tb_de2_115_qsys_key_pio_in.sv
// ============================================================================
// Module : tb_de2_115_qsys_key_pio_in
// Brief  : Scoreboard bench: one undebounced and one 8-cycle debounced PIO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_de2_115_qsys_key_pio_in;

    localparam int DB1 = 8;

    typedef struct packed {
        logic        d;
        logic [31:0] v;
    } rd_exp_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  addr  [2];
    logic        cs    [2];
    logic        wn    [2];
    logic [31:0] wd    [2];
    logic [3:0]  pin   [2];
    logic [31:0] rdata [2];
    logic        irq_w [2];

    int n_checks = 0;
    int n_fail   = 0;

    rd_exp_t sb_q[$];

    // Reference state: last two pin samples, accepted level, previous level, registers.
    logic [3:0] m_h1[2], m_h2[2], m_stable[2], m_prev[2], m_cap[2], m_mask[2];
    int         m_run[2][4];

    de2_115_qsys_key_pio_in #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0), .RESET_LEVEL(1'b1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(addr[0]), .chipselect(cs[0]), .write_n(wn[0]),
        .writedata(wd[0]), .in_port(pin[0]), .readdata(rdata[0]), .irq(irq_w[0]));

    de2_115_qsys_key_pio_in #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(DB1), .RESET_LEVEL(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(addr[1]), .chipselect(cs[1]), .write_n(wn[1]),
        .writedata(wd[1]), .in_port(pin[1]), .readdata(rdata[1]), .irq(irq_w[1]));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int d, input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_stable[d]};
            2'd2:    return {28'd0, m_mask[d]};
            2'd3:    return {28'd0, m_cap[d]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_h1[d] = 4'hF; m_h2[d] = 4'hF; m_stable[d] = 4'hF; m_prev[d] = 4'hF;
            m_cap[d] = 4'h0; m_mask[d] = 4'h0;
            for (int b = 0; b < 4; b++) m_run[d][b] = 0;
        end
        sb_q.delete();
    endtask

    // Reference model: advances once per clock from the bus/pin values held before the edge.
    initial begin
        logic [3:0] e_v;
        logic [3:0] clr_v;
        int         db;
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                for (int d = 0; d < 2; d++) begin
                    db = (d == 0) ? 0 : DB1;
                    if (cs[d] && wn[d]) sb_q.push_back('{d[0], model_read(d, addr[d])});
                    e_v   = ~m_stable[d] & m_prev[d];
                    clr_v = (cs[d] && !wn[d] && addr[d] == 2'd3) ? wd[d][3:0] : 4'h0;
                    if (cs[d] && !wn[d] && addr[d] == 2'd2) m_mask[d] = wd[d][3:0];
                    m_cap[d]  = e_v | (m_cap[d] & ~clr_v);
                    m_prev[d] = m_stable[d];
                    if (db == 0) begin
                        m_stable[d] = m_h1[d];
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (m_h2[d][b] != m_stable[d][b]) begin
                                m_run[d][b]++;
                                if (m_run[d][b] == db) begin
                                    m_stable[d][b] = m_h2[d][b];
                                    m_run[d][b]    = 0;
                                end
                            end else begin
                                m_run[d][b] = 0;
                            end
                        end
                    end
                    m_h2[d] = m_h1[d];
                    m_h1[d] = pin[d];
                end
            end
        end
    end

    // Monitor: drains read expectations and compares irq every cycle.
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("readdata%0d", e.d), rdata[e.d], e.v);
            end
            for (int d = 0; d < 2; d++)
                check($sformatf("irq%0d", d), {31'd0, irq_w[d]}, {31'd0, |(m_cap[d] & m_mask[d])});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_rd(input int d, input logic [1:0] a);
        cs[d] = 1'b1; wn[d] = 1'b1; addr[d] = a;
        @(negedge clk);
        cs[d] = 1'b0;
    endtask

    task automatic bus_wr(input int d, input logic [1:0] a, input logic [31:0] v);
        cs[d] = 1'b1; wn[d] = 1'b0; addr[d] = a; wd[d] = v;
        @(negedge clk);
        cs[d] = 1'b0; wn[d] = 1'b1;
    endtask

    initial begin
        int op;
        clk = 1'b0;
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            addr[d] = 2'd0; cs[d] = 1'b0; wn[d] = 1'b1; wd[d] = 32'd0; pin[d] = 4'hF;
        end
        idle(3);
        check("reset_rd0", rdata[0], 32'd0);
        check("reset_irq0", {31'd0, irq_w[0]}, 32'd0);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // Reset state and no spurious capture on release
        bus_rd(0, 2'd0);
        idle(3);
        bus_rd(0, 2'd3);
        bus_rd(0, 2'd1);

        // Falling edge on bit 1, masked in
        bus_wr(0, 2'd2, 32'h2);
        pin[0] = 4'hD;
        idle(2);
        check("edge_lat_irq_lo", {31'd0, irq_w[0]}, 32'd0);
        idle(1);
        check("edge_lat_irq_hi", {31'd0, irq_w[0]}, 32'd1);
        bus_rd(0, 2'd3);
        bus_rd(0, 2'd0);
        bus_wr(0, 2'd3, 32'h2);
        check("w1c_irq", {31'd0, irq_w[0]}, 32'd0);
        bus_wr(0, 2'd0, 32'h0);
        bus_rd(0, 2'd0);

        // Masked-off capture, then enabling the mask raises irq
        bus_wr(0, 2'd2, 32'h0);
        pin[0] = 4'hC;
        idle(4);
        bus_rd(0, 2'd3);
        check("masked_irq", {31'd0, irq_w[0]}, 32'd0);
        bus_wr(0, 2'd2, 32'h1);
        check("unmask_irq", {31'd0, irq_w[0]}, 32'd1);

        // Clear colliding with a new edge on the same bit
        pin[0] = 4'hD;
        idle(4);
        pin[0] = 4'hC;
        idle(2);
        bus_wr(0, 2'd3, 32'h1);
        check("collide_irq", {31'd0, irq_w[0]}, 32'd1);
        bus_rd(0, 2'd3);

        // Randomised traffic on the undebounced instance
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) pin[0] = 4'($urandom);
            op = int'($urandom_range(0, 3));
            cs[0] = (op != 0); wn[0] = (op != 2); addr[0] = 2'($urandom); wd[0] = $urandom;
            @(negedge clk);
        end
        cs[0] = 1'b0; wn[0] = 1'b1;

        // Debounced instance: short glitch rejected, long low accepted
        bus_wr(1, 2'd2, 32'h8);
        pin[1] = 4'h7;
        idle(5);
        pin[1] = 4'hF;
        idle(15);
        bus_rd(1, 2'd0);
        bus_rd(1, 2'd3);
        check("glitch_irq", {31'd0, irq_w[1]}, 32'd0);
        pin[1] = 4'h7;
        idle(10);
        check("db_irq_lo", {31'd0, irq_w[1]}, 32'd0);
        idle(1);
        check("db_irq_hi", {31'd0, irq_w[1]}, 32'd1);
        idle(9);
        bus_rd(1, 2'd3);
        bus_rd(1, 2'd0);

        // Reset mid-debounce with irq pending
        pin[1] = 4'hF;
        idle(5);
        #2 reset_n = 1'b0;
        #1;
        check("rst_irq1", {31'd0, irq_w[1]}, 32'd0);
        check("rst_rd1", rdata[1], 32'd0);
        idle(2);
        #2 reset_n = 1'b1;
        @(negedge clk);
        bus_rd(1, 2'd2);
        bus_rd(1, 2'd3);

        // Randomised slow-changing pins on the debounced instance
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) pin[1] = 4'($urandom);
            op = int'($urandom_range(0, 3));
            cs[1] = (op != 0); wn[1] = (op != 2); addr[1] = 2'($urandom); wd[1] = $urandom;
            @(negedge clk);
        end
        cs[1] = 1'b0; wn[1] = 1'b1;
        idle(3);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_de2_115_qsys_key_pio_in

`default_nettype wire
